// File: rtl/z80_sram_ctrl.sv
// z80_sram_ctrl: Z80 bus-side controller for a synchronous SRAM with one clock of read latency.
//
// Decodes selected Z80 memory cycles, issues exactly one registered SRAM strobe per cycle,
// holds WAIT low until read data has been captured (plus optional wait states), then
// presents read data to the CPU until MREQ is released.
//
// Optional feature: define Z80_SRAM_CTRL_WAIT_EN to build the WAIT state and its counter
// (WAIT_STATES extra cycles). Without it WAIT_STATES has no effect and CAPT goes to HOLD.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mreq_n, rd_n, wr_n, rfsh_n  Z80 bus controls (synchronous to clk)
//   addr                        Z80 address; addr[15] selects the SRAM
//   cpu_dout / cpu_din          CPU write data in / read data out
//   cpu_din_oe                  high while cpu_din must drive the CPU bus
//   wait_n                      Z80 WAIT, active low, combinational from the bus
//   sram_a, sram_d_in           registered SRAM address and write data
//   sram_d_out                  SRAM read data
//   sram_ce_n/we_n/oe_n         registered SRAM strobes
//   err                         sticky: RD and WR both low on a selected cycle

module z80_sram_ctrl #(
  parameter int unsigned ADR         = 15,
  parameter int unsigned DAT         = 8,
  parameter logic        RAM_SEL     = 1'b1,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mreq_n,
  input  logic           rd_n,
  input  logic           wr_n,
  input  logic           rfsh_n,
  input  logic [15:0]    addr,
  input  logic [DAT-1:0] cpu_dout,
  output logic [DAT-1:0] cpu_din,
  output logic           cpu_din_oe,
  output logic           wait_n,
  output logic [ADR-1:0] sram_a,
  output logic [DAT-1:0] sram_d_in,
  input  logic [DAT-1:0] sram_d_out,
  output logic           sram_ce_n,
  output logic           sram_we_n,
  output logic           sram_oe_n,
  output logic           err
);

`ifdef Z80_SRAM_CTRL_WAIT_EN
  localparam int unsigned WaitEff = WAIT_STATES;
`else
  // Wait states are not built; the parameter is accepted but has no effect.
  localparam int unsigned WaitEff = 0 * WAIT_STATES;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StStrobe,
    StCapt,
    StHold
`ifdef Z80_SRAM_CTRL_WAIT_EN
    , StWait
`endif
  } state_e;

  state_e         state_q;
  logic           rd_q;      // direction of the cycle in flight
  logic           arm_q;     // MREQ seen high since the last accepted cycle
  logic           abort_q;   // MREQ rose while the sequence was in flight
  logic [ADR-1:0] sram_a_q;
  logic [DAT-1:0] sram_d_in_q;
  logic [DAT-1:0] cpu_din_q;
  logic           cpu_din_oe_q;
  logic           ce_n_q;
  logic           we_n_q;
  logic           oe_n_q;
  logic           err_q;
`ifdef Z80_SRAM_CTRL_WAIT_EN
  logic [3:0]     cnt_q;
`endif

  logic sel;
  logic req;
  logic clash;

  assign sel   = !mreq_n && rfsh_n && (addr[15] == RAM_SEL);
  assign req   = sel && (rd_n != wr_n);
  assign clash = sel && !rd_n && !wr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_q         <= 1'b0;
      arm_q        <= 1'b1;
      abort_q      <= 1'b0;
      sram_a_q     <= '0;
      sram_d_in_q  <= '0;
      cpu_din_q    <= '0;
      cpu_din_oe_q <= 1'b0;
      ce_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      err_q        <= 1'b0;
`ifdef Z80_SRAM_CTRL_WAIT_EN
      cnt_q        <= 4'd0;
`endif
    end else begin
      // Any high MREQ ends the current Z80 cycle and re-arms the decoder.
      if (mreq_n) begin
        arm_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          abort_q <= 1'b0;
          if (clash) begin
            err_q <= 1'b1;
          end else if (req && arm_q) begin
            state_q     <= StStrobe;
            arm_q       <= 1'b0;
            rd_q        <= !rd_n;
            sram_a_q    <= addr[ADR-1:0];
            sram_d_in_q <= cpu_dout;
            ce_n_q      <= 1'b0;
            oe_n_q      <= rd_n;
            we_n_q      <= wr_n;
          end
        end
        StStrobe: begin
          // The SRAM acts on the edge ending this state; strobes drop back high here.
          ce_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          state_q <= StCapt;
          if (mreq_n) begin
            abort_q <= 1'b1;
          end
        end
        StCapt: begin
          if (rd_q) begin
            cpu_din_q <= sram_d_out;
          end
          if (mreq_n) begin
            abort_q <= 1'b1;
          end
          if (WaitEff == 0) begin
            if (mreq_n || abort_q) begin
              state_q <= StIdle;
            end else begin
              state_q      <= StHold;
              cpu_din_oe_q <= rd_q;
            end
          end
`ifdef Z80_SRAM_CTRL_WAIT_EN
          else begin
            state_q <= StWait;
            cnt_q   <= 4'(WaitEff);
          end
`endif
        end
`ifdef Z80_SRAM_CTRL_WAIT_EN
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (mreq_n) begin
            abort_q <= 1'b1;
          end
          if (cnt_q == 4'd1) begin
            if (mreq_n || abort_q) begin
              state_q <= StIdle;
            end else begin
              state_q      <= StHold;
              cpu_din_oe_q <= rd_q;
            end
          end
        end
`endif
        StHold: begin
          if (mreq_n) begin
            state_q      <= StIdle;
            cpu_din_oe_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Combinational so that WAIT is pulled in the same cycle the request appears.
  assign wait_n     = rst || !(req && (state_q != StHold));

  assign cpu_din    = cpu_din_q;
  assign cpu_din_oe = cpu_din_oe_q;
  assign sram_a     = sram_a_q;
  assign sram_d_in  = sram_d_in_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_oe_n  = oe_n_q;
  assign err        = err_q;

endmodule

// File: tb/tb_z80_sram_ctrl.sv
// Self-checking bench for z80_sram_ctrl: directed and randomized Z80 memory cycles against a
// behavioural memory model and the cycle-level timing rules of the controller.
module tb_z80_sram_ctrl;

`ifdef Z80_SRAM_CTRL_WAIT_EN
  localparam int W = 1;
`else
  localparam int W = 0;
`endif

  logic        clk;
  logic        rst;
  logic        mreq_n;
  logic        rd_n;
  logic        wr_n;
  logic        rfsh_n;
  logic [15:0] addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_din_oe;
  logic        wait_n;
  logic [14:0] sram_a;
  logic [7:0]  sram_d_in;
  logic [7:0]  sram_d_out;
  logic        sram_ce_n;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        err;

  int checks   = 0;
  int failures = 0;

  z80_sram_ctrl #(
    .ADR(15),
    .DAT(8),
    .RAM_SEL(1'b1),
    .WAIT_STATES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mreq_n(mreq_n),
    .rd_n(rd_n),
    .wr_n(wr_n),
    .rfsh_n(rfsh_n),
    .addr(addr),
    .cpu_dout(cpu_dout),
    .cpu_din(cpu_din),
    .cpu_din_oe(cpu_din_oe),
    .wait_n(wait_n),
    .sram_a(sram_a),
    .sram_d_in(sram_d_in),
    .sram_d_out(sram_d_out),
    .sram_ce_n(sram_ce_n),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous SRAM: acts on the rising edge while its strobes are low.
  logic [7:0] sram_mem [0:32767];
  logic [7:0] sram_q;
  assign sram_d_out = sram_q;

  initial begin
    for (int i = 0; i < 32768; i++) sram_mem[i] = 8'h00;
    sram_q = 8'h00;
  end

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) sram_mem[sram_a] <= sram_d_in;
    if (!sram_ce_n && !sram_oe_n) sram_q <= sram_mem[sram_a];
  end

  // Reference memory: what a read of each SRAM address should return.
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] ref_rd(input logic [14:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 8'h00;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One Z80 memory cycle. abort_at >= 0 raises MREQ at that cycle index.
  task automatic run_txn(input bit rd, input bit wr, input bit rf, input logic [15:0] a,
                         input logic [7:0] d, input int abort_at);
    bit         req;
    int         win;
    int         tail;
    int         n_ce, ce_idx, n_oe, n_we, n_low, first_high, oe_first;
    logic       oe_tail;
    logic [14:0] a_seen;
    logic [7:0]  d_seen;
    logic [7:0]  din_seen;
    logic [7:0]  exp_rd;
    req      = (a[15] == 1'b1) && !rf && (rd != wr);
    exp_rd   = ref_rd(a[14:0]);
    n_ce = 0; ce_idx = -1; n_oe = 0; n_we = 0; n_low = 0; first_high = -1; oe_first = -1;
    oe_tail  = 1'b0;
    a_seen   = '0;
    d_seen   = '0;
    din_seen = '0;
    mreq_n   = 1'b0;
    rd_n     = !rd;
    wr_n     = !wr;
    rfsh_n   = !rf;
    addr     = a;
    cpu_dout = d;
    win  = (abort_at >= 0) ? 3 + W : (req ? 40 : 8);
    tail = (abort_at >= 0) ? 0 : 3;
    for (int i = 0; i < win; i++) begin
      if (i == abort_at) begin
        mreq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
      end
      @(negedge clk);
      if (!sram_ce_n) begin
        n_ce++;
        ce_idx = i;
        a_seen = sram_a;
        d_seen = sram_d_in;
      end
      if (!sram_oe_n) n_oe++;
      if (!sram_we_n) n_we++;
      if (cpu_din_oe && oe_first < 0) oe_first = i;
      if (!wait_n) n_low++;
      else if (req && abort_at < 0) begin
        first_high = i;
        din_seen   = cpu_din;
      end
      @(posedge clk);
      #1;
      if (first_high >= 0) break;
    end
    mreq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    rfsh_n = 1'b1;
    for (int i = 0; i < tail; i++) begin
      @(negedge clk);
      if (!sram_ce_n) n_ce++;
      oe_tail = cpu_din_oe;
      @(posedge clk);
      #1;
    end
    if (req) begin
      check("strobe_count", n_ce, 1);
      check("strobe_cycle", ce_idx, 1);
      check("sram_a", 32'(a_seen), 32'(a[14:0]));
      if (abort_at >= 0) begin
        check("abort_wait_low", n_low, abort_at);
        check("abort_no_oe", oe_first, -1);
      end else begin
        check("wait_release", first_high, 3 + W);
        check("wait_low_cycles", n_low, 3 + W);
      end
      if (rd) begin
        check("rd_oe_pulses", n_oe, 1);
        check("rd_we_pulses", n_we, 0);
        if (abort_at < 0) begin
          check("rd_data", 32'(din_seen), 32'(exp_rd));
          check("rd_din_oe_start", oe_first, 3 + W);
        end
      end else begin
        check("wr_we_pulses", n_we, 1);
        check("wr_oe_pulses", n_oe, 0);
        check("wr_data", 32'(d_seen), 32'(d));
        check("wr_no_din_oe", oe_first, -1);
        ref_mem[int'(a[14:0])] = d;
      end
    end else begin
      check("ignored_no_strobe", n_ce, 0);
      check("ignored_wait_high", n_low, 0);
      check("ignored_no_din_oe", oe_first, -1);
    end
    if (tail > 0) check("din_oe_released", 32'(oe_tail), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ce_n"}, 32'(sram_ce_n), 1);
    check({tag, "_we_n"}, 32'(sram_we_n), 1);
    check({tag, "_oe_n"}, 32'(sram_oe_n), 1);
    check({tag, "_sram_a"}, 32'(sram_a), 0);
    check({tag, "_sram_d_in"}, 32'(sram_d_in), 0);
    check({tag, "_cpu_din"}, 32'(cpu_din), 0);
    check({tag, "_cpu_din_oe"}, 32'(cpu_din_oe), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_wait_n"}, 32'(wait_n), 1);
  endtask

  int          kind;
  logic [15:0] ra;
  logic [7:0]  rdat;

  initial begin
    rst      = 1'b1;
    mreq_n   = 1'b1;
    rd_n     = 1'b1;
    wr_n     = 1'b1;
    rfsh_n   = 1'b1;
    addr     = 16'h0000;
    cpu_dout = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cycles, including the top-of-SRAM boundary.
    run_txn(1'b0, 1'b1, 1'b0, 16'h8012, 8'hA5, -1);
    run_txn(1'b1, 1'b0, 1'b0, 16'h8012, 8'h00, -1);
    run_txn(1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h3C, -1);
    run_txn(1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h00, -1);
    run_txn(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, -1);
    run_txn(1'b1, 1'b0, 1'b1, 16'h8000, 8'h00, -1);
    run_txn(1'b1, 1'b0, 1'b0, 16'h8012, 8'h00, 2);
    // Starts immediately after the abort window: the controller must already be idle.
    run_txn(1'b1, 1'b0, 1'b0, 16'h8012, 8'h00, -1);
    check("err_clear_before_clash", 32'(err), 0);
    run_txn(1'b1, 1'b1, 1'b0, 16'h9000, 8'h00, -1);
    check("err_set_on_clash", 32'(err), 1);

    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 9);
      ra   = {1'b1, ($urandom_range(0, 4) == 0) ? 15'h7FFF : 15'($urandom_range(0, 7))};
      rdat = 8'($urandom);
      if (kind <= 3) run_txn(1'b0, 1'b1, 1'b0, ra, rdat, -1);
      else if (kind <= 7) run_txn(1'b1, 1'b0, 1'b0, ra, rdat, -1);
      else if (kind == 8) run_txn(1'b1, 1'b0, 1'b0, {1'b0, ra[14:0]}, rdat, -1);
      else run_txn(1'b1, 1'b0, 1'b1, ra, rdat, -1);
    end
    check("err_sticky", 32'(err), 1);

    // Leave non-zero read data on cpu_din, then reset in the middle of a strobe.
    run_txn(1'b1, 1'b0, 1'b0, 16'h8012, 8'h00, -1);
    mreq_n = 1'b0;
    rd_n   = 1'b0;
    addr   = 16'h8012;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("strobe_before_reset", 32'(sram_ce_n), 0);
    rst = 1'b1;
    @(negedge clk);
    check("wait_n_during_rst", 32'(wait_n), 1);
    check_reset_values("mid_reset");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mreq_n = 1'b1;
    rd_n   = 1'b1;
    @(posedge clk);
    #1;
    run_txn(1'b1, 1'b0, 1'b0, 16'h8012, 8'h00, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
